// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the datapath control sequencer: opcodes, sequencer
// states and the default immediate width.
package cpu_ctrl_pkg;

  localparam int unsigned IMM_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_LDA  = 2'd0,
    OP_ADDB = 2'd1,
    OP_ADDA = 2'd2,
    OP_MOVB = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_ADD,
    S_WB,
    S_MOV
  } seq_state_e;

endpackage

// File: rtl/control_sequencer.sv
// Micro-sequencer driving DataPath register-transfer strobes through T-states,
// one instruction accepted per handshake while idle.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned IMM_W = cpu_ctrl_pkg::IMM_W_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             instr_valid,
  input  logic [1:0]       instr_op,
  input  logic [IMM_W-1:0] instr_imm,
  output logic             instr_ready,
  output logic             done,
  output logic             RAout,
  output logic             RBout,
  output logic             RZout,
  output logic             RAin,
  output logic             RBin,
  output logic             RZin,
  output logic [IMM_W-1:0] AddImmediate,
  output logic [IMM_W-1:0] RegisterAImmediate
);

  seq_state_e       state_q, state_d;
  op_e              op_q, op_d;
  logic [IMM_W-1:0] imm_q, imm_d;

  logic             ready_d, done_d;
  logic             ra_out_d, rz_out_d, ra_in_d, rb_in_d, rz_in_d;
  logic [IMM_W-1:0] add_imm_d, rega_imm_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d  = op_e'(instr_op);
          imm_d = instr_imm;
          unique case (op_e'(instr_op))
            OP_LDA:           state_d = S_LD;
            OP_ADDB, OP_ADDA: state_d = S_ADD;
            default:          state_d = S_MOV;
          endcase
        end
      end
      S_ADD:   state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops present each
  // T-state's controls for the whole cycle starting at the entering edge.
  always_comb begin
    ready_d    = 1'b0;
    done_d     = 1'b0;
    ra_out_d   = 1'b0;
    rz_out_d   = 1'b0;
    ra_in_d    = 1'b0;
    rb_in_d    = 1'b0;
    rz_in_d    = 1'b0;
    add_imm_d  = '0;
    rega_imm_d = '0;
    unique case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_LD: begin
        rega_imm_d = imm_d;
        ra_in_d    = 1'b1;
        done_d     = 1'b1;
      end
      S_ADD: begin
        ra_out_d  = 1'b1;
        add_imm_d = imm_d;
        rz_in_d   = 1'b1;
      end
      S_WB: begin
        rz_out_d = 1'b1;
        done_d   = 1'b1;
        if (op_d == OP_ADDB) rb_in_d = 1'b1;
        else                 ra_in_d = 1'b1;
      end
      S_MOV: begin
        ra_out_d = 1'b1;
        rb_in_d  = 1'b1;
        done_d   = 1'b1;
      end
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q            <= S_IDLE;
      op_q               <= OP_LDA;
      imm_q              <= '0;
      instr_ready        <= 1'b1;
      done               <= 1'b0;
      RAout              <= 1'b0;
      RZout              <= 1'b0;
      RAin               <= 1'b0;
      RBin               <= 1'b0;
      RZin               <= 1'b0;
      AddImmediate       <= '0;
      RegisterAImmediate <= '0;
    end else begin
      state_q            <= state_d;
      op_q               <= op_d;
      imm_q              <= imm_d;
      instr_ready        <= ready_d;
      done               <= done_d;
      RAout              <= ra_out_d;
      RZout              <= rz_out_d;
      RAin               <= ra_in_d;
      RBin               <= rb_in_d;
      RZin               <= rz_in_d;
      AddImmediate       <= add_imm_d;
      RegisterAImmediate <= rega_imm_d;
    end
  end

  // Reserved bus driver; never used by the current instruction set.
  assign RBout = 1'b0;

endmodule
